// File: rtl/johnson_seq_ctrl.sv
// Johnson (twisted-ring) phase sequencer with run/hold/stop control.
// Counts rotations through phase 0000 and ends a run after len of them.
module johnson_seq_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             dir,
    input  logic [CNT_W-1:0] len,
    input  logic             load,
    input  logic [3:0]       load_val,
    output logic [3:0]       phase,
    output logic [2:0]       phase_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [3:0]       step_val;
    logic [CNT_W-1:0] cnt_inc;
    logic             load_ok;

    always_comb begin
        case (load_val)
            4'b0000, 4'b1000, 4'b1100, 4'b1110,
            4'b1111, 4'b0111, 4'b0011, 4'b0001: load_ok = 1'b1;
            default:                            load_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (phase_q)
            4'b1000: phase_idx = 3'd1;
            4'b1100: phase_idx = 3'd2;
            4'b1110: phase_idx = 3'd3;
            4'b1111: phase_idx = 3'd4;
            4'b0111: phase_idx = 3'd5;
            4'b0011: phase_idx = 3'd6;
            4'b0001: phase_idx = 3'd7;
            default: phase_idx = 3'd0;
        endcase
    end

    assign step_val = dir ? {phase_q[2:0], ~phase_q[3]}
                          : {~phase_q[0], phase_q[3:1]};
    assign cnt_inc  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    // Illegal presets are squashed to 0000 so stepping stays on the ring
                    if (load_ok) begin
                        phase_d = load_val;
                    end else begin
                        phase_d = 4'b0000;
                        err_d   = 1'b1;
                    end
                end else if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (hold) begin
                    state_d = HOLD;
                end else begin
                    phase_d = step_val;
                    if (step_val == 4'b0000) begin
                        cnt_d = cnt_inc;
                        if (len != '0 && cnt_inc == len) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (!hold) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            phase_q <= 4'b0000;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign phase = phase_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed bench for johnson_seq_ctrl: runs, hold, stop, load/err, reset.
// Outputs are sampled 1ns after each rising edge.
module tb_johnson_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, hold, dir, load;
    logic [7:0] len;
    logic [3:0] load_val;
    logic [3:0] phase;
    logic [2:0] phase_idx;
    logic       busy, done, err;

    int checks   = 0;
    int failures = 0;

    logic [3:0] fwd_seq [8] = '{4'h8, 4'hC, 4'hE, 4'hF,
                                4'h7, 4'h3, 4'h1, 4'h0};
    logic [3:0] rev_seq [14] = '{4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1,
                                 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

    johnson_seq_ctrl #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .hold(hold), .dir(dir), .len(len), .load(load),
        .load_val(load_val), .phase(phase), .phase_idx(phase_idx),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; stop = 0; hold = 0; dir = 0;
        load = 0; len = 8'd1; load_val = 4'h0;
        #3 rst = 1'b0;
        #1;
        checks++;
        if (phase !== 4'h0 || busy !== 1'b0 || done !== 1'b0 ||
            err !== 1'b0 || phase_idx !== 3'd0) begin
            failures++;
            $display("FAIL reset phase=%h busy=%b done=%b err=%b idx=%0d exp 0/0/0/0/0",
                     phase, busy, done, err, phase_idx);
        end
        #10 rst = 1'b1;
    endtask

    task automatic test_fwd();
        dir = 0; len = 8'd1; start = 1;
        tick();
        start = 0;
        checks++;
        if (busy !== 1'b1 || phase !== 4'h0) begin
            failures++;
            $display("FAIL fwd_start busy=%b phase=%h exp 1/0", busy, phase);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (phase !== fwd_seq[i] || phase_idx !== 3'((i + 1) % 8)) begin
                failures++;
                $display("FAIL fwd_step%0d phase=%h idx=%0d exp %h/%0d",
                         i + 1, phase, phase_idx, fwd_seq[i], (i + 1) % 8);
            end
            checks++;
            if (done !== (i == 7) || busy !== (i != 7)) begin
                failures++;
                $display("FAIL fwd_ctl%0d done=%b busy=%b exp %b/%b",
                         i + 1, done, busy, i == 7, i != 7);
            end
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL fwd_done_pulse done=%b exp 0", done);
        end
    endtask

    task automatic test_rev();
        load = 1; load_val = 4'h3;
        tick();
        load = 0;
        checks++;
        if (phase !== 4'h3 || phase_idx !== 3'd6 || err !== 1'b0) begin
            failures++;
            $display("FAIL rev_load phase=%h idx=%0d err=%b exp 3/6/0",
                     phase, phase_idx, err);
        end
        dir = 1; len = 8'd2; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if (phase !== rev_seq[i] || done !== (i == 13)) begin
                failures++;
                $display("FAIL rev_step%0d phase=%h done=%b exp %h/%b",
                         i + 1, phase, done, rev_seq[i], i == 13);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rev_end busy=%b exp 0", busy);
        end
        dir = 0;
    endtask

    task automatic test_hold();
        len = 8'd1; start = 1;
        tick();
        start = 0;
        tick();
        tick();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (phase !== 4'hC || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL hold%0d phase=%h busy=%b done=%b exp C/1/0",
                         i, phase, busy, done);
            end
        end
        hold = 0;
        tick();
        checks++;
        if (phase !== 4'hC || busy !== 1'b1) begin
            failures++;
            $display("FAIL hold_resume phase=%h busy=%b exp C/1", phase, busy);
        end
        for (int i = 2; i < 8; i++) begin
            tick();
            checks++;
            if (phase !== fwd_seq[i] || done !== (i == 7)) begin
                failures++;
                $display("FAIL hold_step%0d phase=%h done=%b exp %h/%b",
                         i + 1, phase, done, fwd_seq[i], i == 7);
            end
        end
    endtask

    task automatic test_stop();
        load = 1; load_val = 4'h8;
        tick();
        load = 0; len = 8'd0; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL cont_step%0d done=%b busy=%b exp 0/1",
                         i + 1, done, busy);
            end
        end
        checks++;
        if (phase !== 4'h7) begin
            failures++;
            $display("FAIL cont_phase phase=%h exp 7", phase);
        end
        stop = 1;
        tick();
        stop = 0;
        checks++;
        if (phase !== 4'h7 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL stop phase=%h busy=%b done=%b exp 7/0/0",
                     phase, busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b0 || phase !== 4'h7) begin
            failures++;
            $display("FAIL stop_after done=%b phase=%h exp 0/7", done, phase);
        end
    endtask

    task automatic test_err();
        load = 1; load_val = 4'h4;
        tick();
        checks++;
        if (phase !== 4'h0 || err !== 1'b1) begin
            failures++;
            $display("FAIL err_set phase=%h err=%b exp 0/1", phase, err);
        end
        load_val = 4'h8;
        tick();
        load = 0;
        checks++;
        if (phase !== 4'h8 || err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky phase=%h err=%b exp 8/1", phase, err);
        end
        len = 8'd1; start = 1;
        tick();
        start = 0;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1 || phase !== 4'h8) begin
            failures++;
            $display("FAIL err_clear err=%b busy=%b phase=%h exp 0/1/8",
                     err, busy, phase);
        end
        stop = 1; hold = 1;
        tick();
        stop = 0; hold = 0;
        checks++;
        if (busy !== 1'b0 || phase !== 4'h8) begin
            failures++;
            $display("FAIL stop_over_hold busy=%b phase=%h exp 0/8", busy, phase);
        end
    endtask

    task automatic test_busy_ignore();
        load = 1; start = 1; load_val = 4'h0;
        tick();
        checks++;
        if (busy !== 1'b0 || phase !== 4'h0) begin
            failures++;
            $display("FAIL load_wins busy=%b phase=%h exp 0/0", busy, phase);
        end
        load = 0;
        tick();
        load = 1; load_val = 4'hF;
        tick();
        checks++;
        if (phase !== 4'h8 || busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_ign1 phase=%h busy=%b exp 8/1", phase, busy);
        end
        tick();
        checks++;
        if (phase !== 4'hC || err !== 1'b0) begin
            failures++;
            $display("FAIL busy_ign2 phase=%h err=%b exp C/0", phase, err);
        end
        load = 0; start = 0; stop = 1;
        tick();
        stop = 0;
        checks++;
        if (busy !== 1'b0 || phase !== 4'hC) begin
            failures++;
            $display("FAIL busy_stop busy=%b phase=%h exp 0/C", busy, phase);
        end
    endtask

    task automatic test_midrun_reset();
        len = 8'd1; dir = 0; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 5; i++) tick();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (phase !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_rst phase=%h busy=%b done=%b exp 0/0/0",
                     phase, busy, done);
        end
        #1 rst = 1'b1;
        test_fwd();
    endtask

    initial begin
        test_reset();
        test_fwd();
        test_rev();
        test_hold();
        test_stop();
        test_err();
        test_busy_ignore();
        test_midrun_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
